// File: rtl/rx_frame_sync_if.sv
// Bit-stream handshake bundle for the receive frame aligner.
// Raw side: in_valid/in_data/in_ready. Aligned side: out_valid/out_data/out_ready.
// Status: locked (level) and lock_lost (one-cycle pulse). master = environment, slave = aligner.
interface rx_frame_sync_if;
  logic in_valid;
  logic in_data;
  logic in_ready;
  logic out_valid;
  logic out_data;
  logic out_ready;
  logic locked;
  logic lock_lost;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, locked, lock_lost
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, locked, lock_lost
  );
endinterface

// File: rtl/rx_frame_sync.sv
// Purpose: hunts 6-bit headers in the raw bit stream, confirms frame periodicity, forwards frame-aligned bits.
// Latency: HDR_LEN accepted bits plus one output register stage while locked.
// Backpressure: in LOCK, in_ready = !out_valid | out_ready; in HUNT/VERIFY raw bits are always accepted and discarded.
// Ports: clk, rst (sync, active-high); bus = slave side of rx_frame_sync_if (raw in, aligned out, locked, lock_lost).
module rx_frame_sync #(
  parameter int FRAME_LEN = 102,
  parameter int HDR_LEN   = 6,
  parameter int MAX_ERR   = 1,
  parameter int CONFIRM_N = 2,
  parameter int LOSS_N    = 3
) (
  input  logic           clk,
  input  logic           rst,
  rx_frame_sync_if.slave bus
);

  localparam int CNT_W = $clog2(HDR_LEN + 1);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  state_t               r_state;
  logic [HDR_LEN-1:0]   r_w;
  logic [CNT_W-1:0]     r_fill;
  logic [6:0]           r_pos;
  logic [2:0]           r_good_cnt;
  logic [2:0]           r_miss_cnt;
  logic                 r_out_valid;
  logic                 r_out_data;
  logic                 r_locked;
  logic                 r_lock_lost;

  logic                 w_acc;
  logic [HDR_LEN-1:0]   w_nw;
  logic [CNT_W-1:0]     w_pc;
  logic                 w_hit;
  logic                 w_frame_end;
  logic                 w_in_ready;

  // Window as it will look after this bit is shifted in; newest bit at [0].
  assign w_nw = {r_w[HDR_LEN-2:0], bus.in_data};

  always_comb begin
    w_pc = '0;
    for (int k = 0; k < HDR_LEN; k++) begin
      w_pc = w_pc + CNT_W'(w_nw[k]);
    end
  end

  // A header is either near-all-zeros (data) or near-all-ones (idle).
  // Only trusted once the window holds a full header's worth of real bits.
  assign w_hit = (r_fill >= CNT_W'(HDR_LEN - 1)) &&
                 ((w_pc <= CNT_W'(MAX_ERR)) || (w_pc >= CNT_W'(HDR_LEN - MAX_ERR)));

  assign w_frame_end = (r_pos == 7'(FRAME_LEN - 1));
  assign w_in_ready  = (r_state != S_LOCK) || !r_out_valid || bus.out_ready;
  assign w_acc       = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.locked    = r_locked;
  assign bus.lock_lost = r_lock_lost;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_w         <= '0;
      r_fill      <= '0;
      r_pos       <= '0;
      r_good_cnt  <= '0;
      r_miss_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 1'b0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;

      // A pending output bit drains on out_ready; a forwarding accept below overrides this.
      if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_acc) begin
        r_w <= w_nw;
        if (r_fill != CNT_W'(HDR_LEN)) begin
          r_fill <= r_fill + 1'b1;
        end

        case (r_state)
          S_HUNT: begin
            if (w_hit) begin
              r_pos <= '0;
              if (CONFIRM_N == 1) begin
                r_state    <= S_LOCK;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end else begin
                r_state    <= S_VERIFY;
                r_good_cnt <= 3'd1;
              end
            end
          end

          S_VERIFY: begin
            if (!w_frame_end) begin
              r_pos <= r_pos + 7'd1;
            end else if (w_hit) begin
              r_pos      <= '0;
              r_good_cnt <= r_good_cnt + 3'd1;
              if (r_good_cnt + 3'd1 == 3'(CONFIRM_N)) begin
                r_state    <= S_LOCK;
                r_locked   <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else begin
              // fill is untouched so hunting restarts on the very next bit.
              r_state <= S_HUNT;
            end
          end

          S_LOCK: begin
            // The bit leaving the window is forwarded. On the accept that ends
            // the lock, that bit is still the last payload bit of the previous
            // frame; the bad header never leaves, so output ends on a frame boundary.
            r_out_valid <= 1'b1;
            r_out_data  <= r_w[HDR_LEN-1];
            if (!w_frame_end) begin
              r_pos <= r_pos + 7'd1;
            end else begin
              r_pos <= '0;
              if (w_hit) begin
                r_miss_cnt <= '0;
              end else if (r_miss_cnt + 3'd1 < 3'(LOSS_N)) begin
                r_miss_cnt <= r_miss_cnt + 3'd1;
              end else begin
                r_state     <= S_HUNT;
                r_locked    <= 1'b0;
                r_lock_lost <= 1'b1;
              end
            end
          end

          default: begin
            r_state  <= S_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_sync.sv
module tb_rx_frame_sync;

  localparam int FRAME_LEN = 102;
  localparam int HDR_LEN   = 6;
  localparam int MAX_ERR   = 1;
  localparam int CONFIRM_N = 2;
  localparam int LOSS_N    = 3;
  localparam int NEVER     = 1 << 30;
  localparam int RUN_LIMIT = 20000;

  logic clk;
  logic rst;
  rx_frame_sync_if bus ();

  rx_frame_sync #(
    .FRAME_LEN(FRAME_LEN), .HDR_LEN(HDR_LEN), .MAX_ERR(MAX_ERR),
    .CONFIRM_N(CONFIRM_N), .LOSS_N(LOSS_N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic stream[$];    // bits offered, in order, since the last reset
  logic exp_q[$];     // model: aligned bits still to appear
  logic act_q[$];     // bits seen leaving the DUT
  int   lk_s[$];      // model: accept index completing lock confirmation
  int   lk_e[$];      // model: accept index that loses lock (NEVER if kept)
  int   exp_total;
  int   n_acc = 0;
  bit   last_acc = 1'b0;
  bit   mon_en = 1'b0;
  int   lost_cnt = 0;
  int   act_at_loss = -1;
  int   rdy_pct = 100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hit_at(int i);
    int pc = 0;
    if (i < HDR_LEN - 1) return 1'b0;
    for (int k = i - HDR_LEN + 1; k <= i; k++) pc += int'(stream[k]);
    return (pc <= MAX_ERR) || (pc >= HDR_LEN - MAX_ERR);
  endfunction

  // Frame-level model over the accepted bit sequence: find a header, require
  // CONFIRM_N headers FRAME_LEN apart, then forward from the confirming
  // header's first bit until LOSS_N consecutive periodic misses.
  task automatic build_model();
    int i, h, good, miss, e, n, last;
    bit lost;
    exp_q.delete(); lk_s.delete(); lk_e.delete();
    n = stream.size();
    i = 0;
    while (i < n) begin
      if (!hit_at(i)) begin i++; continue; end
      h = i; good = 1;
      while (good < CONFIRM_N && h + FRAME_LEN < n && hit_at(h + FRAME_LEN)) begin
        h += FRAME_LEN; good++;
      end
      if (good < CONFIRM_N) begin
        if (h + FRAME_LEN >= n) break;
        i = h + FRAME_LEN + 1;
        continue;
      end
      lk_s.push_back(h);
      miss = 0; e = h; lost = 1'b0;
      while (e + FRAME_LEN < n) begin
        e += FRAME_LEN;
        if (hit_at(e)) miss = 0;
        else begin
          miss++;
          if (miss == LOSS_N) begin lost = 1'b1; break; end
        end
      end
      last = lost ? e - HDR_LEN : n - 1 - HDR_LEN;
      for (int k = h - HDR_LEN + 1; k <= last; k++) exp_q.push_back(stream[k]);
      lk_e.push_back(lost ? e : NEVER);
      if (!lost) break;
      i = e + 1;
    end
    exp_total = exp_q.size();
  endtask

  function automatic int model_losses();
    int nl = 0;
    foreach (lk_e[k]) if (lk_e[k] != NEVER) nl++;
    return nl;
  endfunction

  function automatic int first_lock();
    return (lk_s.size() > 0) ? lk_s[0] : -1;
  endfunction

  task automatic add_frame(input logic [5:0] hdr, input bit idle);
    for (int k = HDR_LEN - 1; k >= 0; k--) stream.push_back(hdr[k]);
    for (int k = 0; k < FRAME_LEN - HDR_LEN; k++)
      stream.push_back(idle ? ((k % 4) >= 2) : 1'($urandom_range(1)));
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin : mon
    logic exp_lk, exp_ll;
    if (mon_en) begin
      exp_lk = 1'b0; exp_ll = 1'b0;
      foreach (lk_s[k]) begin
        if (n_acc > lk_s[k] && n_acc <= lk_e[k]) exp_lk = 1'b1;
        if (last_acc && lk_e[k] != NEVER && n_acc == lk_e[k] + 1) exp_ll = 1'b1;
      end
      check("locked", 32'(bus.locked), 32'(exp_lk));
      check("lock_lost", 32'(bus.lock_lost), 32'(exp_ll));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("out_bit_count", act_q.size() + 1, exp_total);
        else check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        act_q.push_back(bus.out_data);
      end
      if (bus.lock_lost) begin
        lost_cnt++;
        if (act_at_loss < 0) act_at_loss = act_q.size();
      end
      if (bus.locked && bus.out_valid && !bus.out_ready)
        check("in_ready_stall", 32'(bus.in_ready), 32'd0);
    end
    last_acc = bus.in_valid && bus.in_ready && !rst;
    if (rst) n_acc = 0;
    else if (last_acc) n_acc++;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic new_test();
    mon_en = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stream.delete(); act_q.delete();
    lost_cnt = 0; act_at_loss = -1;
  endtask

  // Offers the stream bit by bit, holding each bit until accepted.
  task automatic run(input int vpct, input int rpct, input int rst_at);
    int idx = 0;
    int budget = 0;
    bit pend;
    rdy_pct = rpct;
    while (idx < stream.size() && budget < RUN_LIMIT) begin
      if (idx == rst_at) return;
      bus.in_valid = ($urandom_range(99) < vpct);
      bus.in_data  = stream[idx];
      @(negedge clk);
      pend = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (pend) idx++;
      budget++;
    end
    bus.in_valid = 1'b0;
    check("stream_sent", idx, stream.size());
    rdy_pct = 100;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic finish_test(input string name);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_lost_cnt"}, lost_cnt, model_losses());
    mon_en = 1'b0;
  endtask

  initial begin : main
    int fh, base;
    logic [5:0] grp;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_lock_lost", 32'(bus.lock_lost), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Clean data stream, aligned start.
    new_test();
    for (int f = 0; f < 10; f++) add_frame(6'b000000, 1'b0);
    build_model();
    check("t1_lock_at", first_lock(), 107);
    check("t1_fwd_len", exp_total, 912);
    mon_en = 1'b1;
    run(100, 100, -1);
    finish_test("t1");
    for (int g = 0; g < act_q.size() / FRAME_LEN; g++) begin
      for (int k = 0; k < HDR_LEN; k++) grp[k] = act_q[g * FRAME_LEN + k];
      check("t1_group_hdr", 32'(grp), 32'd0);
    end

    // Arbitrary start then idle frames.
    new_test();
    for (int k = 0; k < 37; k++) stream.push_back(1'($urandom_range(1)));
    for (int f = 0; f < 8; f++) add_frame(6'b111111, 1'b1);
    build_model();
    fh = 0;
    for (int f = 0; f < 8; f++) begin
      base = 37 + f * FRAME_LEN;
      for (int i = base + 2 * HDR_LEN - 1; i < base + FRAME_LEN; i++) if (hit_at(i)) fh++;
    end
    check("t2_payload_false_hits", fh, 0);
    check("t2_model_locks", 32'(lk_s.size() > 0), 32'd1);
    mon_en = 1'b1;
    run(100, 100, -1);
    finish_test("t2");

    // One flipped header bit: still a header.
    new_test();
    for (int f = 0; f < 10; f++) add_frame((f == 5) ? 6'b000100 : 6'b000000, 1'b0);
    build_model();
    check("t3a_fwd_len", exp_total, 912);
    mon_en = 1'b1;
    run(100, 100, -1);
    finish_test("t3a");

    // Three bad header bits: one flywheeled miss, lock held.
    new_test();
    for (int f = 0; f < 10; f++) add_frame((f == 5) ? 6'b011100 : 6'b000000, 1'b0);
    build_model();
    check("t3b_fwd_len", exp_total, 912);
    check("t3b_never_lost", model_losses(), 0);
    mon_en = 1'b1;
    run(100, 100, -1);
    finish_test("t3b");

    // Loss of lock on three consecutive bad headers, then re-lock.
    new_test();
    for (int f = 0; f < 14; f++) add_frame((f >= 5 && f <= 7) ? 6'b010101 : 6'b000000, 1'b0);
    build_model();
    check("t4_lock_at", first_lock(), 107);
    check("t4_loss_at", (lk_e.size() > 0) ? lk_e[0] : -1, 719);
    check("t4_relock", 32'(lk_s.size() >= 2), 32'd1);
    mon_en = 1'b1;
    run(100, 100, -1);
    check("t4_bits_at_loss", act_at_loss, 6 * FRAME_LEN);
    check("t4_lost_once", lost_cnt, 1);
    finish_test("t4");

    // Backpressure and input gaps while locked.
    new_test();
    for (int f = 0; f < 12; f++) add_frame(6'b000000, 1'b0);
    build_model();
    mon_en = 1'b1;
    run(70, 50, -1);
    finish_test("t5");

    // Reset in LOCK at pos 50, then re-acquire.
    new_test();
    for (int f = 0; f < 6; f++) add_frame(6'b000000, 1'b0);
    build_model();
    mon_en = 1'b1;
    run(100, 100, 158);
    check("t6_locked_before_rst", 32'(bus.locked), 32'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_locked", 32'(bus.locked), 32'd0);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    stream.delete(); act_q.delete();
    lost_cnt = 0; act_at_loss = -1;
    for (int f = 0; f < 4; f++) add_frame(6'b000000, 1'b0);
    build_model();
    check("t6_relock_at", first_lock(), 107);
    mon_en = 1'b1;
    run(100, 100, -1);
    finish_test("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
